// File: rtl/register_file_sweep_if.sv
// ---------------------------------------------------------------------------
// register_file_sweep_if
//   Bundles the decode-stage register file's control, write, read and status
//   signals so the pipeline (master) and the register file (slave) share one
//   port. Clock and reset are kept as plain ports on the register file.
//
//   Signals (direction seen from the register file):
//     i_clear        in   restart the init sweep
//     i_step         in   pipeline advance, qualifies write-back
//     i_wr_en        in   write-back enable
//     i_dir_wr       in   write-back address
//     i_wr_data      in   write-back data
//     i_dir_rs       in   read address, port rs
//     i_dir_rt       in   read address, port rt
//     i_RegDebug     in   debug read/write address
//     i_dbg_wr_en    in   debug write enable
//     i_dbg_wr_data  in   debug write data
//     o_data_rs      out  read data, port rs
//     o_data_rt      out  read data, port rt
//     o_RegDebug     out  debug read data
//     o_busy         out  init sweep in progress
//     o_wr_conflict  out  debug and write-back hit the same entry last cycle
// ---------------------------------------------------------------------------
interface register_file_sweep_if #(
  parameter int REGS = 5,
  parameter int NB   = 32
);
  logic            i_clear;
  logic            i_step;
  logic            i_wr_en;
  logic [REGS-1:0] i_dir_wr;
  logic [NB-1:0]   i_wr_data;
  logic [REGS-1:0] i_dir_rs;
  logic [REGS-1:0] i_dir_rt;
  logic [REGS-1:0] i_RegDebug;
  logic            i_dbg_wr_en;
  logic [NB-1:0]   i_dbg_wr_data;
  logic [NB-1:0]   o_data_rs;
  logic [NB-1:0]   o_data_rt;
  logic [NB-1:0]   o_RegDebug;
  logic            o_busy;
  logic            o_wr_conflict;

  modport master (
    output i_clear, i_step, i_wr_en, i_dir_wr, i_wr_data,
           i_dir_rs, i_dir_rt, i_RegDebug, i_dbg_wr_en, i_dbg_wr_data,
    input  o_data_rs, o_data_rt, o_RegDebug, o_busy, o_wr_conflict
  );

  modport slave (
    input  i_clear, i_step, i_wr_en, i_dir_wr, i_wr_data,
           i_dir_rs, i_dir_rt, i_RegDebug, i_dbg_wr_en, i_dbg_wr_data,
    output o_data_rs, o_data_rt, o_RegDebug, o_busy, o_wr_conflict
  );
endinterface

// File: rtl/register_file_sweep.sv
// ---------------------------------------------------------------------------
// register_file_sweep
//   Decode-stage register file for the MIPS pipeline. Two combinational read
//   ports (rs, rt) with optional write-back bypass, a debug read port without
//   bypass, a write-back port gated by the pipeline step and an ungated debug
//   write port. After reset or a clear request an init sweep writes one entry
//   per cycle (value = index or zero) before normal operation resumes.
//
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  asynchronous active-high reset (restarts the sweep)
//     bus      register_file_sweep_if slave modport (see interface file)
// ---------------------------------------------------------------------------
module register_file_sweep #(
  parameter int REGS     = 5,
  parameter int NB       = 32,
  parameter int TAM      = 32,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  parameter int INIT_IDX = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  register_file_sweep_if.slave bus
);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One extra bit so TAM == 2**REGS is representable for the bound checks.
  localparam logic [REGS:0] TAM_L  = TAM[REGS:0];
  localparam logic [REGS:0] LAST_L = TAM_L - 1'b1;

  state_t          state_q, state_d;
  logic [REGS:0]   cnt_q, cnt_d;
  logic            conflict_q, conflict_d;
  logic [NB-1:0]   mem_q [TAM];
  logic [NB-1:0]   mem_d [TAM];

  logic            wb_valid;
  logic            dbg_valid;
  logic            same_addr;
  logic [NB-1:0]   sweep_val;

  // An entry is usable when it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [REGS-1:0] a);
    return ({1'b0, a} < TAM_L) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  // Write qualification shared by the array update, conflict flag and bypass.
  always_comb begin
    wb_valid  = (state_q == RUN) && bus.i_wr_en && bus.i_step && addr_ok(bus.i_dir_wr);
    dbg_valid = (state_q == RUN) && bus.i_dbg_wr_en && addr_ok(bus.i_RegDebug);
    same_addr = (bus.i_dir_wr == bus.i_RegDebug);
    sweep_val = (INIT_IDX != 0) ? NB'(cnt_q) : '0;
  end

  // Next-state logic: clear beats every write, the sweep ignores the write
  // ports, and in RUN the debug write wins a same-address collision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;
    mem_d      = mem_q;

    if (bus.i_clear) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      mem_d[cnt_q[REGS-1:0]] = sweep_val;
      if (cnt_q == LAST_L) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (wb_valid && !(dbg_valid && same_addr)) begin
        mem_d[bus.i_dir_wr] = bus.i_wr_data;
      end
      if (dbg_valid) begin
        mem_d[bus.i_RegDebug] = bus.i_dbg_wr_data;
      end
      conflict_d = wb_valid && dbg_valid && same_addr;
    end
  end

  // State register. The array sits in the same process but is deliberately
  // left out of the reset branch: reset restarts the sweep without touching
  // the stored contents, and the array simply holds while reset is asserted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= SWEEP;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      mem_q      <= mem_d;
    end
  end

  // Read ports: zero while sweeping or for unusable addresses. rs/rt may take
  // the in-flight write-back data; the debug port always shows the array.
  always_comb begin
    bus.o_data_rs  = '0;
    bus.o_data_rt  = '0;
    bus.o_RegDebug = '0;
    if (state_q == RUN) begin
      if (addr_ok(bus.i_dir_rs)) begin
        if ((BYPASS != 0) && wb_valid && (bus.i_dir_wr == bus.i_dir_rs)) begin
          bus.o_data_rs = bus.i_wr_data;
        end else begin
          bus.o_data_rs = mem_q[bus.i_dir_rs];
        end
      end
      if (addr_ok(bus.i_dir_rt)) begin
        if ((BYPASS != 0) && wb_valid && (bus.i_dir_wr == bus.i_dir_rt)) begin
          bus.o_data_rt = bus.i_wr_data;
        end else begin
          bus.o_data_rt = mem_q[bus.i_dir_rt];
        end
      end
      if (addr_ok(bus.i_RegDebug)) begin
        bus.o_RegDebug = mem_q[bus.i_RegDebug];
      end
    end
  end

  assign bus.o_busy        = (state_q == SWEEP);
  assign bus.o_wr_conflict = conflict_q;

endmodule

// File: tb/tb_register_file_sweep.sv
// ---------------------------------------------------------------------------
// tb_register_file_sweep
//   Directed bench for register_file_sweep with default parameters
//   (32 x 32-bit, R0 hardwired, bypass on, sweep writes the index).
//   A table of single-cycle vectors covers reads, bypass, step gating, R0,
//   and debug/write-back collisions; hand-written sequences cover the sweep
//   length after reset, clear during RUN and reset in the middle of a sweep.
// ---------------------------------------------------------------------------
module tb_register_file_sweep;

  logic clk;
  logic rst;

  int n_applied;
  int n_miscompares;

  register_file_sweep_if #(.REGS(5), .NB(32)) bus ();

  register_file_sweep #(
    .REGS(5), .NB(32), .TAM(32), .ZERO_R0(1), .BYPASS(1), .INIT_IDX(1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic        wr_en;
    logic [4:0]  dir_wr;
    logic [31:0] wr_data;
    logic        dbg_wr_en;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_dbg;
    logic        exp_conf;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int s, input int w, input int dw, input int d,
                              input int de, input int da, input int dd,
                              input int rs, input int rt,
                              input int ers, input int ert, input int edb, input int ec);
    vec_t v;
    v.step      = s[0];
    v.wr_en     = w[0];
    v.dir_wr    = dw[4:0];
    v.wr_data   = d;
    v.dbg_wr_en = de[0];
    v.dbg_addr  = da[4:0];
    v.dbg_data  = dd;
    v.rs        = rs[4:0];
    v.rt        = rt[4:0];
    v.exp_rs    = ers;
    v.exp_rt    = ert;
    v.exp_dbg   = edb;
    v.exp_conf  = ec[0];
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.i_clear       = 1'b0;
    bus.i_step        = 1'b0;
    bus.i_wr_en       = 1'b0;
    bus.i_dir_wr      = 5'd0;
    bus.i_wr_data     = 32'd0;
    bus.i_dir_rs      = 5'd0;
    bus.i_dir_rt      = 5'd0;
    bus.i_RegDebug    = 5'd0;
    bus.i_dbg_wr_en   = 1'b0;
    bus.i_dbg_wr_data = 32'd0;
  endtask

  // Drives one vector after a falling edge, checks the combinational outputs
  // before the next rising edge; inputs stay put across that edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    set_idle();
    bus.i_step        = v.step;
    bus.i_wr_en       = v.wr_en;
    bus.i_dir_wr      = v.dir_wr;
    bus.i_wr_data     = v.wr_data;
    bus.i_dbg_wr_en   = v.dbg_wr_en;
    bus.i_RegDebug    = v.dbg_addr;
    bus.i_dbg_wr_data = v.dbg_data;
    bus.i_dir_rs      = v.rs;
    bus.i_dir_rt      = v.rt;
    #1;
    tag = $sformatf("v%0d", idx);
    check_output({tag, " rs"},   bus.o_data_rs,  v.exp_rs);
    check_output({tag, " rt"},   bus.o_data_rt,  v.exp_rt);
    check_output({tag, " dbg"},  bus.o_RegDebug, v.exp_dbg);
    check_output({tag, " conf"}, 32'(bus.o_wr_conflict), 32'(v.exp_conf));
    check_output({tag, " busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  // Counts rising edges from now until o_busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.o_busy) break;
    end
  endtask

  initial begin
    int n;
    n_applied     = 0;
    n_miscompares = 0;

    // Fields: step, wr_en, dir_wr, wr_data, dbg_wr_en, dbg_addr, dbg_data,
    //         rs, rt, exp_rs, exp_rt, exp_dbg, exp_conf
    vecs[0]  = mk(0,0, 0,'h0,     0, 3,'h0,    7, 8,  7,     8,     3,     0);
    vecs[1]  = mk(1,1, 5,'hDEAD,  0, 5,'h0,    5, 6,  'hDEAD,6,     5,     0);
    vecs[2]  = mk(0,1, 6,'hBEEF,  0, 6,'h0,    6, 5,  6,     'hDEAD,6,     0);
    vecs[3]  = mk(1,1, 0,'hFF,    0, 0,'h0,    0, 0,  0,     0,     0,     0);
    vecs[4]  = mk(0,0, 0,'h0,     0, 0,'h0,    0, 6,  0,     6,     0,     0);
    vecs[5]  = mk(1,1, 9,'h5678,  1, 9,'h1234, 9,10,  'h5678,10,    9,     0);
    vecs[6]  = mk(0,0, 0,'h0,     0, 9,'h0,    9, 9,  'h1234,'h1234,'h1234,1);
    vecs[7]  = mk(0,0, 0,'h0,     0, 9,'h0,    5,31,  'hDEAD,31,    'h1234,0);
    vecs[8]  = mk(1,1,21,'hBBBB,  1,20,'hAAAA,21,20,  'hBBBB,20,    20,    0);
    vecs[9]  = mk(0,0, 0,'h0,     0,21,'h0,   21,20,  'hBBBB,'hAAAA,'hBBBB,0);
    vecs[10] = mk(0,0, 0,'h0,     1, 0,'h77,   0,31,  0,     31,    0,     0);
    vecs[11] = mk(0,0, 0,'h0,     0, 0,'h0,    0, 2,  0,     2,     0,     0);

    // Reset: busy and zeroed reads are visible while reset is held.
    set_idle();
    rst = 1'b1;
    bus.i_dir_rs = 5'd7;
    #2;
    check_output("reset busy", 32'(bus.o_busy), 32'd1);
    check_output("reset conf", 32'(bus.o_wr_conflict), 32'd0);
    check_output("reset rs", bus.o_data_rs, 32'd0);

    // Release and keep both write ports active: the sweep must ignore them.
    @(negedge clk);
    rst               = 1'b0;
    bus.i_step        = 1'b1;
    bus.i_wr_en       = 1'b1;
    bus.i_dir_wr      = 5'd7;
    bus.i_wr_data     = 32'h999;
    bus.i_dbg_wr_en   = 1'b1;
    bus.i_RegDebug    = 5'd8;
    bus.i_dbg_wr_data = 32'h888;
    #1;
    check_output("sweep rs", bus.o_data_rs, 32'd0);
    check_output("sweep dbg", bus.o_RegDebug, 32'd0);
    count_busy(n);
    check_output("init sweep cycles", 32'(n), 32'd32);

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // Clear during RUN with colliding writes: writes dropped, no conflict.
    @(negedge clk);
    set_idle();
    bus.i_clear       = 1'b1;
    bus.i_step        = 1'b1;
    bus.i_wr_en       = 1'b1;
    bus.i_dir_wr      = 5'd3;
    bus.i_wr_data     = 32'h5555;
    bus.i_dbg_wr_en   = 1'b1;
    bus.i_RegDebug    = 5'd3;
    bus.i_dbg_wr_data = 32'h6666;
    #1;
    check_output("pre-clear busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;
    set_idle();
    check_output("clear busy", 32'(bus.o_busy), 32'd1);
    check_output("clear conf", 32'(bus.o_wr_conflict), 32'd0);
    count_busy(n);
    check_output("clear sweep cycles", 32'(n), 32'd32);
    apply_stimulus(mk(0,0,0,0, 0,9,0, 3,5, 3,5,9,0), 100);
    apply_stimulus(mk(0,0,0,0, 0,21,0, 20,0, 20,0,21,0), 101);

    // Plant a marker, clear, then reset once 12 entries have been swept.
    apply_stimulus(mk(1,1,20,'hCAFE, 0,20,0, 1,2, 1,2,20,0), 102);
    @(negedge clk);
    set_idle();
    bus.i_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.i_clear = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("mid-sweep reset busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check_output("restart sweep cycles", 32'(n), 32'd32);
    apply_stimulus(mk(0,0,0,0, 0,19,0, 20,12, 20,12,19,0), 103);
    apply_stimulus(mk(0,0,0,0, 0,31,0, 0,5, 0,5,31,0), 104);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
